mem_port_arbiter: RTL and testbench

- Shares the single-port synchronous instruction/data RAM between two requesters:
  - the instruction-fetch path (PC-addressed reads);
  - the data path (LDR reads / STR writes).
- Fixed priority to data accesses, with a starvation guard that forces a fetch grant after a bounded number of consecutive data wins.
- Sits between the CPU sequencer/datapath and the RAM. Sequences every access as grant → RAM cycle → read-latency wait → ack.

---
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port synchronous RAM between the instruction-fetch path
//   (reads only) and the data path (reads and writes). Data has priority, but
//   after MAX_STARVE consecutive data grants made while a fetch was waiting,
//   the next contended grant goes to fetch.
//
//   Every access runs IDLE -> ACCESS -> [WAIT x READ_LAT] -> DONE -> IDLE.
//   Writes skip WAIT. All outputs except busy come straight from registers.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   if_req/if_addr        fetch request (level, held until if_ack)
//   if_rdata/if_ack       fetch read data (registered), 1-cycle completion
//   d_req/d_we/d_addr     data request, 1=write
//   d_wdata               write data
//   d_rdata/d_ack         data read data (registered), 1-cycle completion
//   mem_addr/mem_rd/      RAM address and strobes; strobes only ever high
//   mem_wr/mem_wdata      during ACCESS, never together
//   mem_rdata             RAM read data, valid READ_LAT cycles after mem_rd
//   busy                  high whenever the FSM is not IDLE
//   owner                 0=fetch, 1=data, owner of current/last transaction
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int READ_LAT   = 1,
  parameter int MAX_STARVE = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam int CW = $clog2(READ_LAT + 1);
  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam logic [CW-1:0] LAT_LAST   = CW'(READ_LAT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_starve;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_we;
  logic          r_owner;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_if_ack;
  logic          r_d_ack;
  logic          r_mem_rd;
  logic          r_mem_wr;

  // Contention rule: data wins unless fetch has already lost MAX_STARVE times
  // in a row while waiting.
  logic w_force_fetch;
  logic w_grant_d;
  logic w_grant_if;

  assign w_force_fetch = if_req && (r_starve == STARVE_MAX);
  assign w_grant_d     = d_req && !w_force_fetch;
  assign w_grant_if    = if_req && !w_grant_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_starve   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_owner    <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
    end else begin
      // Pulse outputs default low; strobes are loaded at the grant edge so
      // they are high exactly during the ACCESS cycle.
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_owner  <= 1'b1;
            r_we     <= d_we;
            r_addr   <= d_addr;
            r_wdata  <= d_wdata;
            r_mem_rd <= !d_we;
            r_mem_wr <= d_we;
            r_state  <= S_ACCESS;
            // Only count wins that actually held off a waiting fetch.
            if (if_req && (r_starve != STARVE_MAX))
              r_starve <= r_starve + SW'(1);
          end else if (w_grant_if) begin
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= if_addr;
            r_mem_rd <= 1'b1;
            r_state  <= S_ACCESS;
            r_starve <= '0;
          end
        end

        S_ACCESS: begin
          if (r_we) begin
            // Write is committed by the RAM at this edge; ack next cycle.
            r_d_ack <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= CW'(1);
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (r_cnt == LAT_LAST) begin
            // Only the owner's read register moves; the other holds.
            if (r_owner) begin
              r_d_rdata <= mem_rdata;
              r_d_ack   <= 1'b1;
            end else begin
              r_if_rdata <= mem_rdata;
              r_if_ack   <= 1'b1;
            end
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DONE: begin
          // Requester drops req at this edge, so IDLE never re-grants it.
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_ack    = r_if_ack;
  assign d_ack     = r_d_ack;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign owner     = r_owner;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiters side by side: inst 0 (READ_LAT=1) and inst 1 (READ_LAT=3),
// both MAX_STARVE=2, each with its own behavioural RAM.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   [2];
  logic        if_req  [2];
  logic        d_req   [2];
  logic        d_we    [2];
  logic        if_ack  [2];
  logic        d_ack   [2];
  logic        mem_rd  [2];
  logic        mem_wr  [2];
  logic        busy    [2];
  logic        owner   [2];
  logic [7:0]  if_addr [2];
  logic [7:0]  d_addr  [2];
  logic [7:0]  mem_addr[2];
  logic [15:0] d_wdata [2];
  logic [15:0] if_rdata[2];
  logic [15:0] d_rdata [2];
  logic [15:0] mem_wdata[2];
  logic [15:0] mem_rdata[2];

  logic [15:0] ram [2][256];
  logic [15:0] rp  [2][3];
  logic        pl_en;
  int          pl_n;
  logic [7:0]  pl_a;
  logic [15:0] pl_d;

  int errors = 0;
  int checks = 0;
  int nack[2];

  typedef struct {
    int          n;
    logic        own;
    logic [15:0] ifd;
    logic [15:0] dd;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_if[2];
  logic [15:0] m_d [2];

  function automatic int rl(input int n);
    return (n == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RAM model: read pipeline returns a marker when no read was issued, so a
  // capture on the wrong cycle shows up as a data error.
  always @(posedge clk) begin
    if (pl_en) ram[pl_n][pl_a] <= pl_d;
    for (int n = 0; n < 2; n++) begin
      if (mem_wr[n]) ram[n][mem_addr[n]] <= mem_wdata[n];
      rp[n][0] <= mem_rd[n] ? ram[n][mem_addr[n]] : 16'hDEAD;
      rp[n][1] <= rp[n][0];
      rp[n][2] <= rp[n][1];
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .AW(8), .DW(16), .READ_LAT((g == 0) ? 1 : 3), .MAX_STARVE(2)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n[g]),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_rdata (if_rdata[g]),
      .if_ack   (if_ack[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_rdata  (d_rdata[g]),
      .d_ack    (d_ack[g]),
      .mem_addr (mem_addr[g]),
      .mem_rd   (mem_rd[g]),
      .mem_wr   (mem_wr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .busy     (busy[g]),
      .owner    (owner[g])
    );

    assign mem_rdata[g] = rp[g][(g == 0) ? 0 : 2];

    // Scoreboard consumer: every ack must match the oldest pending expectation.
    always @(negedge clk) begin
      exp_t e;
      chk("strobe_excl", {31'd0, mem_rd[g] & mem_wr[g]}, 32'd0);
      if (if_ack[g] || d_ack[g]) begin
        nack[g]++;
        chk("ack_expected", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("ack_inst", g, e.n);
          chk("ack_owner", {29'd0, if_ack[g], d_ack[g], owner[g]}, e.own ? 32'd3 : 32'd4);
          chk("if_rdata", {16'd0, if_rdata[g]}, {16'd0, e.ifd});
          chk("d_rdata", {16'd0, d_rdata[g]}, {16'd0, e.dd});
        end
      end
    end
  end

  task automatic preload(input int n, input logic [7:0] a, input logic [15:0] d);
    pl_n = n; pl_a = a; pl_d = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic expect_x(input int n, input bit dat, input bit we, input logic [7:0] a);
    if (!we) begin
      if (dat) m_d[n] = ram[n][a];
      else     m_if[n] = ram[n][a];
    end
    sb.push_back('{n, dat, m_if[n], m_d[n]});
  endtask

  // One isolated transaction; must be called at posedge+#1 with the DUT idle.
  task automatic xact(input int n, input bit dat, input bit we,
                      input logic [7:0] a, input logic [15:0] wd);
    int k, nrd, nwr;
    bit done;
    expect_x(n, dat, we, a);
    if (dat) begin
      d_we[n] = we; d_addr[n] = a; d_wdata[n] = wd; d_req[n] = 1'b1;
    end else begin
      if_addr[n] = a; if_req[n] = 1'b1;
    end
    @(posedge clk); #1;
    // Scramble address/data after the grant edge: the arbiter must not care.
    if (dat) begin d_addr[n] = ~a; d_wdata[n] = ~wd; end
    else if_addr[n] = ~a;
    k = 0; nrd = 0; nwr = 0; done = 1'b0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
      if (k == 1) chk("busy_owner", {30'd0, busy[n], owner[n]}, {30'd0, 1'b1, dat});
      if (mem_rd[n]) begin nrd++; chk("rd_addr", {24'd0, mem_addr[n]}, {24'd0, a}); end
      if (mem_wr[n]) begin nwr++; chk("wr_addr_data", {8'd0, mem_addr[n], mem_wdata[n]}, {8'd0, a, wd}); end
      done = dat ? d_ack[n] : if_ack[n];
    end
    chk("latency", k, we ? 2 : 2 + rl(n));
    chk("rd_cnt", nrd, {31'd0, !we});
    chk("wr_cnt", nwr, {31'd0, we});
    @(posedge clk); #1;
    if (dat) d_req[n] = 1'b0; else if_req[n] = 1'b0;
  endtask

  // Wait for a number of acks with requests already raised.
  task automatic wait_acks(input int n, input int want, input bit drop_each);
    int got;
    bit wasd;
    got = 0;
    for (int c = 0; c < 80 && got < want; c++) begin
      @(negedge clk);
      if (d_ack[n] || if_ack[n]) begin
        got++;
        wasd = d_ack[n];
        @(posedge clk); #1;
        if (drop_each) begin
          if (wasd) d_req[n] = 1'b0; else if_req[n] = 1'b0;
        end
      end
    end
    chk("ack_count", got, want);
    if_req[n] = 1'b0;
    d_req[n]  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input int n);
    chk("rst_rdata", {if_rdata[n], d_rdata[n]}, 32'd0);
    chk("rst_mem", {mem_addr[n], mem_wdata[n]}, 32'd0);
    chk("rst_ctl", {26'd0, if_ack[n], d_ack[n], mem_rd[n], mem_wr[n], busy[n], owner[n]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    pl_en = 1'b0; pl_n = 0; pl_a = '0; pl_d = '0;
    for (int n = 0; n < 2; n++) begin
      rst_n[n] = 1'b0; if_req[n] = 1'b0; d_req[n] = 1'b0; d_we[n] = 1'b0;
      if_addr[n] = '0; d_addr[n] = '0; d_wdata[n] = '0;
      m_if[n] = '0; m_d[n] = '0; nack[n] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals(0);
    chk_reset_vals(1);
    @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    preload(0, 8'h05, 16'hABCD);
    preload(0, 8'h20, 16'h5A5A);
    preload(1, 8'h33, 16'hBEEF);
    preload(1, 8'h40, 16'h1357);

    // Instance 0, READ_LAT=1
    xact(0, 1'b0, 1'b0, 8'h05, 16'h0);          // fetch read
    xact(0, 1'b1, 1'b1, 8'h10, 16'h1234);       // data write
    chk("ram_written", {16'd0, ram[0][8'h10]}, 32'h1234);
    xact(0, 1'b1, 1'b0, 8'h10, 16'h0);          // data read, fetch rdata held
    xact(0, 1'b1, 1'b1, 8'hFF, 16'hC0DE);       // top of address range
    chk("ram_top", {16'd0, ram[0][8'hFF]}, 32'hC0DE);

    // Simultaneous requests: data first, then fetch
    expect_x(0, 1'b1, 1'b0, 8'h10);
    expect_x(0, 1'b0, 1'b0, 8'h05);
    d_we[0] = 1'b0; d_addr[0] = 8'h10; if_addr[0] = 8'h05;
    if_req[0] = 1'b1; d_req[0] = 1'b1;
    wait_acks(0, 2, 1'b1);

    // Starvation guard: both held high -> D,D,F repeating (counter clears on F)
    d_we[0] = 1'b0; d_addr[0] = 8'h20; if_addr[0] = 8'h05;
    for (int r = 0; r < 2; r++) begin
      expect_x(0, 1'b1, 1'b0, 8'h20);
      expect_x(0, 1'b1, 1'b0, 8'h20);
      expect_x(0, 1'b0, 1'b0, 8'h05);
    end
    if_req[0] = 1'b1; d_req[0] = 1'b1;
    wait_acks(0, 6, 1'b0);
    chk("sb_drained0", sb.size(), 0);

    // Instance 1, READ_LAT=3
    xact(1, 1'b0, 1'b0, 8'h33, 16'h0);          // fetch, ack 5 cycles in
    xact(1, 1'b1, 1'b1, 8'h41, 16'h2468);
    xact(1, 1'b1, 1'b0, 8'h41, 16'h0);

    // Reset during WAIT of a data read: no ack, everything back to zero
    d_we[1] = 1'b0; d_addr[1] = 8'h40; d_req[1] = 1'b1;
    @(posedge clk);                              // grant -> ACCESS
    @(posedge clk);                              // -> WAIT
    @(negedge clk);
    chk("busy_in_wait", {31'd0, busy[1]}, 32'd1);
    rst_n[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals(1);
    d_req[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    base = nack[1];
    repeat (8) @(posedge clk);
    #1;
    chk("no_ack_after_rst", nack[1], base);
    m_if[1] = '0; m_d[1] = '0;
    xact(1, 1'b0, 1'b0, 8'h40, 16'h0);          // re-issued after reset
    chk("sb_drained1", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
